// File: rtl/serial_adder_5bit_pkg.sv
// Shared definitions for the serial adder and the ripple-carry adder tests:
// FSM state encodings and the default operand width.
package serial_adder_5bit_pkg;

  // Default operand/sum width of the adder datapath.
  localparam int DEFAULT_WIDTH = 5;

  // Controller states; encodings are fixed so other benches can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_adder_5bit_pkg

// File: rtl/serial_adder_5bit_fa_bit.sv
// One-bit full adder cell, the only arithmetic element of the serial adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum is the three-way parity; carry is the majority of the inputs.
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : fa_bit

// File: rtl/serial_adder_5bit.sv
// Bit-serial LSB-first adder. Operands and carry-in are latched on an accepted
// start, then one bit per clock is resolved through a single full-adder cell
// with a registered carry. {cout,sum} = a + b + cin, presented with a one-cycle
// done pulse and held until the next completion.
module serial_adder_5bit
  import serial_adder_5bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,  // 2..16
  parameter int CNT_W = 3               // 2**CNT_W must exceed WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_t           state_reg;
  state_t           state_next;
  logic             load;        // operands are captured on this edge
  logic             last_bit;    // this edge resolves the MSB

  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  // Only the upper WIDTH-1 result bits need storage: the MSB is taken straight
  // from the adder cell on the final edge.
  logic [WIDTH-2:0] part_reg;
  logic [WIDTH-2:0] part_shift;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic             bit_s;
  logic             bit_co;

  fa_bit u_fa_bit (
    .a  (sa_reg[0]),
    .b  (sb_reg[0]),
    .ci (carry_reg),
    .s  (bit_s),
    .co (bit_co)
  );

  // New sum bit enters at the top of the partial register; narrowest width
  // degenerates to a single flop.
  generate
    if (WIDTH > 2) begin : g_part_wide
      assign part_shift = {bit_s, part_reg[WIDTH-2:1]};
    end else begin : g_part_single
      assign part_shift = bit_s;
    end
  endgenerate

  assign last_bit = (state_reg == ST_RUN) && (cnt_reg == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and operand-load decode; start is only honoured outside RUN.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_bit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Serial datapath: load operands, then shift one bit per RUN cycle and
  // publish the result on the final bit only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_reg    <= '0;
      sb_reg    <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      part_reg  <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else if (load) begin
      sa_reg    <= a;
      sb_reg    <= b;
      carry_reg <= cin;
      cnt_reg   <= '0;
      part_reg  <= '0;
    end else if (state_reg == ST_RUN) begin
      sa_reg    <= {1'b0, sa_reg[WIDTH-1:1]};
      sb_reg    <= {1'b0, sb_reg[WIDTH-1:1]};
      carry_reg <= bit_co;
      part_reg  <= part_shift;
      cnt_reg   <= cnt_reg + CNT_W'(1);
      if (last_bit) begin
        sum_reg  <= {bit_s, part_reg};
        cout_reg <= bit_co;
      end
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule : serial_adder_5bit
